// File: rtl/uni_arbiter.sv
// uni_arbiter: two-requester (IFU/LSU) arbiter onto one memory port, LSU priority with IFU starvation guard
module uni_arbiter #(
   parameter int CPU_WIDTH  = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_ifu_valid,
   output logic                 o_ifu_ready,
   input  logic [CPU_WIDTH-1:0] i_ifu_addr,
   input  logic [1:0]           i_ifu_size,
   output logic [CPU_WIDTH-1:0] o_ifu_rdata,
   input  logic                 i_lsu_valid,
   output logic                 o_lsu_ready,
   input  logic [CPU_WIDTH-1:0] i_lsu_addr,
   input  logic                 i_lsu_reqtyp,
   input  logic [CPU_WIDTH-1:0] i_lsu_wdata,
   input  logic [1:0]           i_lsu_size,
   output logic [CPU_WIDTH-1:0] o_lsu_rdata,
   output logic                 o_mem_valid,
   input  logic                 i_mem_ready,
   output logic [CPU_WIDTH-1:0] o_mem_addr,
   output logic [CPU_WIDTH-1:0] o_mem_wdata,
   output logic                 o_mem_reqtyp,
   output logic [1:0]           o_mem_size,
   input  logic [CPU_WIDTH-1:0] i_mem_rdata,
   output logic [1:0]           o_grant
);
   typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;
   state_t     state_q, state_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       gnt_ifu, gnt_lsu, starve_hit;
   assign gnt_ifu    = state_q == GNT_IFU;
   assign gnt_lsu    = state_q == GNT_LSU;
   assign starve_hit = starve_cnt_q == 4'(STARVE_MAX);
   // IFU wins a tie only once the LSU has been granted STARVE_MAX times in a row over it
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         IDLE:
            if (i_ifu_valid && (!i_lsu_valid || starve_hit)) begin
               state_d      = GNT_IFU;
               starve_cnt_d = '0;
            end else if (i_lsu_valid) begin
               state_d = GNT_LSU;
               if (i_ifu_valid && !starve_hit) starve_cnt_d = starve_cnt_q + 4'd1;
            end
         GNT_IFU, GNT_LSU:
            if (o_mem_valid && i_mem_ready) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   assign o_mem_valid  = (gnt_ifu && i_ifu_valid) || (gnt_lsu && i_lsu_valid);
   assign o_mem_addr   = gnt_ifu ? i_ifu_addr : gnt_lsu ? i_lsu_addr : '0;
   assign o_mem_size   = gnt_ifu ? i_ifu_size : gnt_lsu ? i_lsu_size : '0;
   assign o_mem_wdata  = gnt_lsu ? i_lsu_wdata : '0;
   assign o_mem_reqtyp = gnt_lsu && i_lsu_reqtyp;
   assign o_ifu_ready  = gnt_ifu && o_mem_valid && i_mem_ready;
   assign o_lsu_ready  = gnt_lsu && o_mem_valid && i_mem_ready;
   assign o_ifu_rdata  = gnt_ifu ? i_mem_rdata : '0;
   assign o_lsu_rdata  = gnt_lsu ? i_mem_rdata : '0;
   assign o_grant      = {gnt_lsu, gnt_ifu};
endmodule

// File: tb/tb_uni_arbiter.sv
// tb_uni_arbiter: directed scenario tests for uni_arbiter with hand-computed expectations
module tb_uni_arbiter;
   localparam int W = 64;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         ifu_valid = 0, lsu_valid = 0, lsu_reqtyp = 0, mem_ready = 0;
   logic [W-1:0] ifu_addr = '0, lsu_addr = '0, lsu_wdata = '0, mem_rdata = '0;
   logic [1:0]   ifu_size = '0, lsu_size = '0;
   logic         o_ifu_ready, o_lsu_ready, o_mem_valid, o_mem_reqtyp;
   logic [W-1:0] o_ifu_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata;
   logic [1:0]   o_mem_size, o_grant;
   logic         any_out;
   int           checks = 0, fails = 0;

   always #5 clk = ~clk;

   uni_arbiter #(.CPU_WIDTH(W), .STARVE_MAX(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_ifu_valid(ifu_valid), .o_ifu_ready(o_ifu_ready), .i_ifu_addr(ifu_addr),
      .i_ifu_size(ifu_size), .o_ifu_rdata(o_ifu_rdata),
      .i_lsu_valid(lsu_valid), .o_lsu_ready(o_lsu_ready), .i_lsu_addr(lsu_addr),
      .i_lsu_reqtyp(lsu_reqtyp), .i_lsu_wdata(lsu_wdata), .i_lsu_size(lsu_size),
      .o_lsu_rdata(o_lsu_rdata),
      .o_mem_valid(o_mem_valid), .i_mem_ready(mem_ready), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_reqtyp(o_mem_reqtyp), .o_mem_size(o_mem_size),
      .i_mem_rdata(mem_rdata), .o_grant(o_grant)
   );

   assign any_out = |{o_ifu_ready, o_ifu_rdata, o_lsu_ready, o_lsu_rdata, o_mem_valid,
                      o_mem_addr, o_mem_wdata, o_mem_reqtyp, o_mem_size, o_grant};

   // invariants sampled every cycle; only violations add to the counts
   always @(negedge clk) begin
      if (o_grant === 2'b11) begin
         checks++; fails++;
         $display("FAIL inv_grant11: grant=%b required !=11", o_grant);
      end
      if (o_ifu_ready === 1'b1 && o_lsu_ready === 1'b1) begin
         checks++; fails++;
         $display("FAIL inv_both_ready: ifu_ready=1 lsu_ready=1 required not both");
      end
      if (o_grant === 2'b00 && o_mem_valid !== 1'b0) begin
         checks++; fails++;
         $display("FAIL inv_idle_valid: mem_valid=%b required 0 in IDLE", o_mem_valid);
      end
   end

   task automatic test_reset;
      @(negedge clk);
      checks++; if (any_out !== 1'b0) begin fails++; $display("FAIL reset_outputs: any_out=%b required 0", any_out); end
      checks++; if (dut.starve_cnt_q !== 4'd0) begin fails++; $display("FAIL reset_starve: got %0d required 0", dut.starve_cnt_q); end
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00) begin fails++; $display("FAIL reset_release_grant: got %b required 00", o_grant); end
   endtask

   task automatic test_ifu_read;
      int n = 0;
      @(posedge clk); #1;
      ifu_valid = 1; ifu_addr = 64'h8000_0000; ifu_size = 2'd2; mem_ready = 0;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00 || o_mem_valid !== 1'b0) begin fails++; $display("FAIL ifu_arb_cycle: grant=%b valid=%b required 00/0", o_grant, o_mem_valid); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (i == 2) begin mem_ready = 1; mem_rdata = 64'h1234; end
         @(negedge clk);
         checks++; if (o_grant !== 2'b01) begin fails++; $display("FAIL ifu_grant_hold[%0d]: got %b required 01", i, o_grant); end
         checks++;
         if (o_mem_valid !== 1'b1 || o_mem_addr !== 64'h8000_0000 || o_mem_size !== 2'd2 || o_mem_reqtyp !== 1'b0) begin
            fails++; $display("FAIL ifu_mem_fwd[%0d]: valid=%b addr=%h size=%0d typ=%b required 1/80000000/2/0", i, o_mem_valid, o_mem_addr, o_mem_size, o_mem_reqtyp);
         end
         if (o_ifu_ready === 1'b1) n++;
      end
      checks++; if (o_ifu_ready !== 1'b1 || o_ifu_rdata !== 64'h1234) begin fails++; $display("FAIL ifu_rdata: ready=%b rdata=%h required 1/1234", o_ifu_ready, o_ifu_rdata); end
      @(posedge clk); #1 ifu_valid = 0; mem_ready = 0; mem_rdata = '0;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00 || o_ifu_ready !== 1'b0) begin fails++; $display("FAIL ifu_back_idle: grant=%b ready=%b required 00/0", o_grant, o_ifu_ready); end
      checks++; if (n != 1) begin fails++; $display("FAIL ifu_ready_pulses: got %0d required 1", n); end
   endtask

   task automatic test_both;
      @(posedge clk); #1;
      ifu_valid = 1; ifu_addr = 64'h1000; ifu_size = 2'd2;
      lsu_valid = 1; lsu_addr = 64'h2000; lsu_reqtyp = 1; lsu_wdata = 64'hAA; lsu_size = 2'd1;
      mem_ready = 1; mem_rdata = 64'h77;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00) begin fails++; $display("FAIL both_arb: got %b required 00", o_grant); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b10) begin fails++; $display("FAIL both_lsu_first: got %b required 10", o_grant); end
      checks++;
      if (o_mem_addr !== 64'h2000 || o_mem_reqtyp !== 1'b1 || o_mem_size !== 2'd1 || o_mem_wdata !== 64'hAA) begin
         fails++; $display("FAIL both_lsu_fwd: addr=%h typ=%b size=%0d wdata=%h required 2000/1/1/aa", o_mem_addr, o_mem_reqtyp, o_mem_size, o_mem_wdata);
      end
      checks++;
      if (o_lsu_ready !== 1'b1 || o_lsu_rdata !== 64'h77 || o_ifu_ready !== 1'b0 || o_ifu_rdata !== '0) begin
         fails++; $display("FAIL both_lsu_resp: lr=%b lrd=%h ir=%b ird=%h required 1/77/0/0", o_lsu_ready, o_lsu_rdata, o_ifu_ready, o_ifu_rdata);
      end
      checks++; if (dut.starve_cnt_q !== 4'd1) begin fails++; $display("FAIL both_starve_inc: got %0d required 1", dut.starve_cnt_q); end
      @(posedge clk); #1 lsu_valid = 0;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00) begin fails++; $display("FAIL both_idle_gap: got %b required 00", o_grant); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b01) begin fails++; $display("FAIL both_ifu_second: got %b required 01", o_grant); end
      checks++;
      if (o_mem_addr !== 64'h1000 || o_mem_reqtyp !== 1'b0 || o_mem_wdata !== '0 || o_ifu_ready !== 1'b1 || o_ifu_rdata !== 64'h77) begin
         fails++; $display("FAIL both_ifu_fwd: addr=%h typ=%b wdata=%h ir=%b ird=%h required 1000/0/0/1/77", o_mem_addr, o_mem_reqtyp, o_mem_wdata, o_ifu_ready, o_ifu_rdata);
      end
      checks++; if (dut.starve_cnt_q !== 4'd0) begin fails++; $display("FAIL both_starve_clr: got %0d required 0", dut.starve_cnt_q); end
      @(posedge clk); #1 ifu_valid = 0; mem_ready = 0;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00) begin fails++; $display("FAIL both_end_idle: got %b required 00", o_grant); end
   endtask

   task automatic test_drop_valid;
      @(posedge clk); #1;
      ifu_valid = 1; ifu_addr = 64'h3000; ifu_size = 2'd0; mem_ready = 0;
      @(negedge clk);
      @(posedge clk); #1 ifu_valid = 0; mem_ready = 1;
      @(negedge clk);
      checks++;
      if (o_grant !== 2'b01 || o_mem_valid !== 1'b0 || o_ifu_ready !== 1'b0) begin
         fails++; $display("FAIL drop_hold: grant=%b valid=%b ready=%b required 01/0/0", o_grant, o_mem_valid, o_ifu_ready);
      end
      @(posedge clk); #1 ifu_valid = 1;
      @(negedge clk);
      checks++;
      if (o_grant !== 2'b01 || o_mem_valid !== 1'b1 || o_ifu_ready !== 1'b1) begin
         fails++; $display("FAIL drop_resume: grant=%b valid=%b ready=%b required 01/1/1", o_grant, o_mem_valid, o_ifu_ready);
      end
      @(posedge clk); #1 ifu_valid = 0; mem_ready = 0;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00) begin fails++; $display("FAIL drop_end: got %b required 00", o_grant); end
   endtask

   task automatic test_starve;
      logic [1:0] exp [12] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10,
                               2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      @(posedge clk); #1;
      ifu_valid = 1; lsu_valid = 1; lsu_reqtyp = 0; mem_ready = 1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         checks++; if (o_grant !== exp[i]) begin fails++; $display("FAIL starve_seq[%0d]: got %b required %b", i, o_grant, exp[i]); end
         if (i == 8) begin
            checks++; if (dut.starve_cnt_q !== 4'd4) begin fails++; $display("FAIL starve_sat: got %0d required 4", dut.starve_cnt_q); end
         end
         if (i == 9) begin
            checks++; if (dut.starve_cnt_q !== 4'd0) begin fails++; $display("FAIL starve_clear: got %0d required 0", dut.starve_cnt_q); end
         end
      end
      @(posedge clk); #1 ifu_valid = 0; lsu_valid = 0; mem_ready = 0;
      @(negedge clk);
   endtask

   task automatic test_write;
      int n = 0;
      @(posedge clk); #1;
      lsu_valid = 1; lsu_reqtyp = 1; lsu_addr = 64'h8000_0010; lsu_wdata = 64'hDEAD_BEEF;
      lsu_size = 2'd3; mem_ready = 1; mem_rdata = 64'h55;
      @(negedge clk);
      checks++; if (any_out !== 1'b0) begin fails++; $display("FAIL write_idle_zero: any_out=%b required 0", any_out); end
      @(posedge clk); #1;
      @(negedge clk);
      if (o_lsu_ready === 1'b1) n++;
      checks++;
      if (o_grant !== 2'b10 || o_mem_valid !== 1'b1 || o_mem_addr !== 64'h8000_0010 || o_mem_wdata !== 64'hDEAD_BEEF || o_mem_size !== 2'd3 || o_mem_reqtyp !== 1'b1) begin
         fails++; $display("FAIL write_fwd: g=%b v=%b a=%h d=%h s=%0d t=%b required 10/1/80000010/deadbeef/3/1", o_grant, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_size, o_mem_reqtyp);
      end
      checks++; if (o_lsu_rdata !== 64'h55 || o_ifu_rdata !== '0) begin fails++; $display("FAIL write_rdata: lsu=%h ifu=%h required 55/0", o_lsu_rdata, o_ifu_rdata); end
      @(posedge clk); #1 lsu_valid = 0; mem_ready = 0;
      @(negedge clk);
      if (o_lsu_ready === 1'b1) n++;
      checks++; if (n != 1) begin fails++; $display("FAIL write_ready_pulses: got %0d required 1", n); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1;
      lsu_valid = 1; lsu_reqtyp = 0; lsu_addr = 64'h40; mem_ready = 0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b10) begin fails++; $display("FAIL rmid_granted: got %b required 10", o_grant); end
      checks++; if (dut.starve_cnt_q !== 4'd1) begin fails++; $display("FAIL rmid_starve_pre: got %0d required 1", dut.starve_cnt_q); end
      #2 rst_n = 0;
      #1;
      checks++; if (any_out !== 1'b0) begin fails++; $display("FAIL rmid_async_zero: any_out=%b required 0", any_out); end
      checks++; if (dut.starve_cnt_q !== 4'd0) begin fails++; $display("FAIL rmid_starve_clr: got %0d required 0", dut.starve_cnt_q); end
      @(posedge clk); #1;
      lsu_valid = 0; ifu_valid = 1; ifu_addr = 64'h200; ifu_size = 2'd2; mem_ready = 1;
      @(negedge clk);
      checks++; if (any_out !== 1'b0) begin fails++; $display("FAIL rmid_held_zero: any_out=%b required 0", any_out); end
      @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00 || o_ifu_ready !== 1'b0) begin fails++; $display("FAIL rmid_first_idle: grant=%b ready=%b required 00/0", o_grant, o_ifu_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (o_grant !== 2'b01 || o_ifu_ready !== 1'b1) begin fails++; $display("FAIL rmid_ifu_grant: grant=%b ready=%b required 01/1", o_grant, o_ifu_ready); end
      @(posedge clk); #1 ifu_valid = 0; mem_ready = 0;
      @(negedge clk);
      checks++; if (o_grant !== 2'b00 || o_lsu_ready !== 1'b0) begin fails++; $display("FAIL rmid_end: grant=%b lsu_ready=%b required 00/0", o_grant, o_lsu_ready); end
   endtask

   initial begin
      test_reset;
      test_ifu_read;
      test_both;
      test_drop_valid;
      test_starve;
      test_write;
      test_reset_mid;
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
